// File: rtl/spi_readout_pkg.sv
// Shared types and constants for the SPI readout path.
// READ_PARITY_EN adds the odd-parity PAR state.
package spi_readout_pkg;

`ifdef READ_PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
   typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

   localparam logic [7:0] CHIP_ID        = 8'hA5;
   localparam logic [7:0] ADDR_TRIG      = 8'd1;
   localparam logic [7:0] ADDR_INSTR     = 8'd2;
   localparam logic [7:0] ADDR_MODE      = 8'd3;
   localparam logic [7:0] ADDR_ANALOG_LO = 8'd4;
   localparam logic [7:0] ADDR_ANALOG_HI = 8'd59;
   localparam logic [7:0] INVALID_BYTE   = 8'hFF;

endpackage

// File: rtl/readout_byte_select.sv
// Combinational address decode choosing the byte to be read out.
module readout_byte_select
   import spi_readout_pkg::*;
(
   input  logic [7:0] addr,
   input  logic [7:0] trig_mask,
   input  logic [7:0] instruction,
   input  logic [7:0] mode,
   input  logic [7:0] analog_byte,
   output logic [7:0] sel_byte
);

   always_comb begin
      sel_byte = INVALID_BYTE;
      if (addr == 8'd0) begin
         sel_byte = CHIP_ID;
      end else if (addr == ADDR_TRIG) begin
         sel_byte = trig_mask;
      end else if (addr == ADDR_INSTR) begin
         sel_byte = instruction;
      end else if (addr == ADDR_MODE) begin
         sel_byte = mode;
      end else if (addr >= ADDR_ANALOG_LO && addr <= ADDR_ANALOG_HI) begin
         sel_byte = analog_byte;
      end
   end

endmodule

// File: rtl/readout_serializer.sv
// MSB-first register readout shifter for the SPI slave.
// Define READ_PARITY_EN to append one odd-parity bit after each byte.
module readout_serializer
   import spi_readout_pkg::*;
(
   input  logic       sclk,
   input  logic       rst,
   input  logic       cs_active,
   input  logic       msg_flag,
   input  logic [7:0] addr,
   input  logic [7:0] trig_mask,
   input  logic [7:0] instruction,
   input  logic [7:0] mode,
   input  logic [7:0] analog_byte,
   output logic       serial_out,
   output logic       busy,
   output logic [7:0] byte_cnt,
   output logic       overrun
);

   state_e     state_q;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       busy_q;
   logic [7:0] byte_cnt_q;
   logic       overrun_q;
   logic [7:0] sel_byte;
`ifdef READ_PARITY_EN
   logic       par_q;
`endif

   readout_byte_select u_byte_select (
      .addr        (addr),
      .trig_mask   (trig_mask),
      .instruction (instruction),
      .mode        (mode),
      .analog_byte (analog_byte),
      .sel_byte    (sel_byte)
   );

   // serial_out is always the MSB of the shift register; idle leaves it zeroed.
   always_ff @(posedge sclk) begin
      if (rst || !cs_active) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         busy_q     <= 1'b0;
         byte_cnt_q <= '0;
         overrun_q  <= 1'b0;
`ifdef READ_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else if (msg_flag) begin
         if (state_q == StShift && bit_cnt_q != 3'd7) begin
            overrun_q <= 1'b1;
         end
         state_q   <= StShift;
         shift_q   <= sel_byte;
         bit_cnt_q <= '0;
         busy_q    <= 1'b1;
         if (byte_cnt_q != 8'hFF) begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
         end
`ifdef READ_PARITY_EN
         par_q     <= ~(^sel_byte);
`endif
      end else begin
         unique case (state_q)
            StShift: begin
               if (bit_cnt_q != 3'd7) begin
                  shift_q   <= {shift_q[6:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
               end else begin
                  bit_cnt_q <= '0;
`ifdef READ_PARITY_EN
                  state_q   <= StPar;
                  shift_q   <= {par_q, 7'b0};
`else
                  state_q   <= StIdle;
                  shift_q   <= '0;
                  busy_q    <= 1'b0;
`endif
               end
            end
`ifdef READ_PARITY_EN
            StPar: begin
               state_q <= StIdle;
               shift_q <= '0;
               busy_q  <= 1'b0;
            end
`endif
            default: begin
               state_q <= StIdle;
               shift_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out = shift_q[7];
   assign busy       = busy_q;
   assign byte_cnt   = byte_cnt_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_readout_serializer.sv
// Bench for readout_serializer: bit-queue model checked every cycle plus directed literals.
module tb_readout_serializer;

   logic       sclk = 1'b0;
   logic       rst;
   logic       cs_active;
   logic       msg_flag;
   logic [7:0] addr;
   logic [7:0] trig_mask;
   logic [7:0] instruction;
   logic [7:0] mode;
   logic [7:0] analog_byte;
   logic       serial_out;
   logic       busy;
   logic [7:0] byte_cnt;
   logic       overrun;

   int total = 0;
   int bad   = 0;

`ifdef READ_PARITY_EN
   localparam int Cyc = 9;
`else
   localparam int Cyc = 8;
`endif

   readout_serializer dut (
      .sclk        (sclk),
      .rst         (rst),
      .cs_active   (cs_active),
      .msg_flag    (msg_flag),
      .addr        (addr),
      .trig_mask   (trig_mask),
      .instruction (instruction),
      .mode        (mode),
      .analog_byte (analog_byte),
      .serial_out  (serial_out),
      .busy        (busy),
      .byte_cnt    (byte_cnt),
      .overrun     (overrun)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [7:0] a);
      if (a == 8'd0) return 8'hA5;
      if (a == 8'd1) return trig_mask;
      if (a == 8'd2) return instruction;
      if (a == 8'd3) return mode;
      if (a >= 8'd4 && a <= 8'd59) return analog_byte;
      return 8'hFF;
   endfunction

   // Model: queue of bits still to appear on serial_out, each tagged data/parity.
   logic [1:0] mq[$];
   int         m_cnt = 0;
   bit         m_ovr = 1'b0;
   bit         model_valid = 1'b0;

   always @(posedge sclk) begin
      logic [7:0] b;
      bit         data_left;
      if (rst || !cs_active) begin
         mq.delete();
         m_cnt = 0;
         m_ovr = 1'b0;
         if (rst) model_valid = 1'b1;
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (msg_flag) begin
            data_left = 1'b0;
            for (int i = 0; i < mq.size(); i++) if (mq[i][1]) data_left = 1'b1;
            if (data_left) m_ovr = 1'b1;
            mq.delete();
            b = exp_byte(addr);
            for (int i = 7; i >= 0; i--) mq.push_back({1'b1, b[i]});
`ifdef READ_PARITY_EN
            mq.push_back({1'b0, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0});
`endif
            if (m_cnt < 255) m_cnt++;
         end
      end
   end

   always @(negedge sclk) begin
      if (model_valid) begin
         check("serial_out", int'(serial_out), (mq.size() > 0) ? int'(mq[0][0]) : 0);
         check("busy", int'(busy), (mq.size() > 0) ? 1 : 0);
         check("byte_cnt", int'(byte_cnt), m_cnt);
         check("overrun", int'(overrun), int'(m_ovr));
      end
   end

   task automatic tick();
      @(negedge sclk);
   endtask

   task automatic clear_frame();
      msg_flag  = 1'b0;
      cs_active = 1'b0;
      tick();
      cs_active = 1'b1;
   endtask

   logic [7:0]  cap;
   logic [15:0] cap16;
   int          nb;
   logic [7:0]  addr_list [6];

   initial begin
      rst = 1'b1; cs_active = 1'b0; msg_flag = 1'b0; addr = '0;
      trig_mask = 8'h00; instruction = 8'h00; mode = 8'h00; analog_byte = 8'h00;
      tick(); tick();
      check("reset_serial", int'(serial_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_byte_cnt", int'(byte_cnt), 0);
      rst = 1'b0;
      cs_active = 1'b1;
      tick();

      // instruction byte C3
      addr = 8'd2; instruction = 8'hC3; msg_flag = 1'b1;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         tick(); msg_flag = 1'b0;
         cap[7-i] = serial_out;
         nb += int'(busy);
      end
      check("c3_bits", int'(cap), 'hC3);
      check("c3_busy_cycles", nb, 8);
      check("c3_byte_cnt", int'(byte_cnt), 1);
      tick();
`ifdef READ_PARITY_EN
      check("c3_par_bit", int'(serial_out), 1);
      check("c3_par_busy", int'(busy), 1);
`else
      check("c3_after_busy", int'(busy), 0);
`endif

      // back-to-back A5 then FF
      clear_frame();
      addr = 8'd0; msg_flag = 1'b1;
      cap16 = '0;
      for (int i = 0; i < 2 * Cyc; i++) begin
         tick(); msg_flag = 1'b0;
         if ((i % Cyc) < 8) cap16[15 - (i / Cyc) * 8 - (i % Cyc)] = serial_out;
         if (i == Cyc - 1) begin addr = 8'd60; msg_flag = 1'b1; end
      end
      check("b2b_bits", int'(cap16), 'hA5FF);
      check("b2b_overrun", int'(overrun), 0);
      check("b2b_byte_cnt", int'(byte_cnt), 2);

      // abort after 3 cycles, then 0F in full; later input changes ignored
      clear_frame();
      addr = 8'd1; trig_mask = 8'hF0; msg_flag = 1'b1;
      tick(); msg_flag = 1'b0;
      tick(); tick();
      addr = 8'd5; analog_byte = 8'h0F; msg_flag = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(); msg_flag = 1'b0; analog_byte = 8'hAA;
         cap[7-i] = serial_out;
      end
      check("abort_bits", int'(cap), 'h0F);
      check("abort_overrun", int'(overrun), 1);

      // cs drop with simultaneous msg_flag mid-byte
      addr = 8'd3; mode = 8'h55; msg_flag = 1'b1;
      tick(); msg_flag = 1'b0;
      tick(); tick();
      cs_active = 1'b0; msg_flag = 1'b1;
      tick();
      check("csdrop_serial", int'(serial_out), 0);
      check("csdrop_busy", int'(busy), 0);
      check("csdrop_byte_cnt", int'(byte_cnt), 0);
      check("csdrop_overrun", int'(overrun), 0);
      msg_flag = 1'b0; cs_active = 1'b1;
      tick();

      // reset mid-byte
      addr = 8'd3; mode = 8'h07; msg_flag = 1'b1;
      tick(); msg_flag = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("rst_serial", int'(serial_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_byte_cnt", int'(byte_cnt), 0);
      check("rst_overrun", int'(overrun), 0);
      rst = 1'b0;
      tick();

      // full mode=07 byte and its trailing bit
      addr = 8'd3; mode = 8'h07; msg_flag = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(); msg_flag = 1'b0;
         cap[7-i] = serial_out;
      end
      check("mode07_bits", int'(cap), 'h07);
      tick();
      check("mode07_ninth_serial", int'(serial_out), 0);
`ifdef READ_PARITY_EN
      check("mode07_ninth_busy", int'(busy), 1);
`else
      check("mode07_ninth_busy", int'(busy), 0);
`endif

      // address decode sweep, checked by the model
      addr_list[0] = 8'd4;  addr_list[1] = 8'd59; addr_list[2] = 8'd60;
      addr_list[3] = 8'd255; addr_list[4] = 8'd1; addr_list[5] = 8'd3;
      clear_frame();
      trig_mask = 8'h81; mode = 8'h6E;
      for (int k = 0; k < 6; k++) begin
         addr = addr_list[k]; analog_byte = 8'h3C ^ addr_list[k]; msg_flag = 1'b1;
         for (int i = 0; i < Cyc; i++) begin
            tick(); msg_flag = 1'b0;
         end
      end

      // byte_cnt saturation via continuous reloads
      clear_frame();
      addr = 8'd0; msg_flag = 1'b1;
      repeat (260) tick();
      check("sat_byte_cnt", int'(byte_cnt), 255);
      check("sat_overrun", int'(overrun), 1);
      msg_flag = 1'b0;
      repeat (Cyc + 2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/readout_serializer.md
READOUT_SERIALIZER -- requirements
Module: readout_serializer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL be updated on the posedge of sclk only.
REQ-002 SHALL have ports: sclk  in  1  SPI clock, sole clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cs_active  in  1  frame enable; low = no transaction.
REQ-005 msg_flag  in  1  one-cycle byte-boundary pulse from the upstream deserializer.
REQ-006 addr  in  8  current register address (auto-incremented upstream).
REQ-007 trig_mask, instruction, mode  in  8 each  contents of addresses 1, 2, 3.
REQ-008 analog_byte  in  8  byte returned by the analog register bank for addresses 4..59.
REQ-009 serial_out  out  1  readout bit, MSB first.
REQ-010 busy  out  1  high while a byte (or parity bit) is being shifted.
REQ-011 byte_cnt  out  8  bytes loaded in current frame.
REQ-012 overrun  out  1  sticky: a byte was reloaded before fully shifted.

Function
REQ-013 Byte select: addr 0 -> CHIP_ID (8'hA5); 1 -> trig_mask; 2 -> instruction; 3 -> mode; 4..59 -> analog_byte; >=60 -> 8'hFF.
REQ-014 States: IDLE, SHIFT, PAR (PAR exists only with READ_PARITY_EN).
REQ-015 IDLE: serial_out=0, busy=0; on cs_active & msg_flag, load selected byte into 8-bit shift register, bit_cnt=0, go to SHIFT.
REQ-016 Latency: bit 7 of the loaded byte SHALL appear on serial_out in the cycle immediately after the msg_flag edge; bit (7-n) in cycle n+1.
REQ-017 SHIFT: shift left once per cycle; after the 8th bit (bit_cnt=7) go to PAR if enabled, else IDLE.
REQ-018 msg_flag in SHIFT at bit_cnt=7 (or in PAR) SHALL reload back-to-back with no gap cycle and no overrun.
REQ-019 msg_flag in SHIFT at bit_cnt<7 SHALL abort the current byte, reload, restart bit_cnt=0, and set overrun.
REQ-020 byte_cnt SHALL increment on each load and saturate at 255.
REQ-021 cs_active low SHALL, on the next edge, force IDLE and clear shift register, bit_cnt, byte_cnt, overrun; it takes priority over a simultaneous msg_flag.
REQ-022 Byte value is sampled on the load edge only; input changes during shifting SHALL NOT affect serial_out.

Reset
REQ-023 rst high SHALL force IDLE, serial_out=0, busy=0, byte_cnt=0, overrun=0, shift register=0, bit_cnt=0 on the next edge, overriding all other inputs including mid-byte.

Configuration
REQ-024 Macro READ_PARITY_EN defined: after each 8 data bits one PAR cycle outputs odd parity (ones count over 9 bits odd), busy high during PAR; undefined: no PAR state, 8 cycles per byte.

Structure
REQ-025 Package spi_readout_pkg SHALL hold: state enum, CHIP_ID, ADDR_TRIG=1, ADDR_INSTR=2, ADDR_MODE=3, ADDR_ANALOG_LO=4, ADDR_ANALOG_HI=59, INVALID_BYTE=8'hFF.
REQ-026 Sub-module readout_byte_select SHALL implement REQ-013 combinationally.

Verification
REQ-027 addr=2, instruction=8'hC3, msg_flag pulse -> serial_out 1,1,0,0,0,0,1,1 over next 8 cycles, busy high 8 cycles, byte_cnt=1.
REQ-028 addr=0 then addr=60 back-to-back at 8-cycle spacing -> 8'hA5 then 8'hFF contiguous, overrun=0, byte_cnt=2.
REQ-029 msg_flag again 3 cycles after load (addr=5, analog_byte=8'h0F) -> first byte truncated, 8'h0F shifted in full, overrun=1.
REQ-030 cs_active low and msg_flag same cycle mid-byte -> next cycle IDLE, serial_out=0, byte_cnt=0, overrun=0.
REQ-031 rst at bit 4 of a byte -> all outputs at reset values next cycle; with READ_PARITY_EN, mode=8'h07 -> 9th bit = 0.
